// File: rtl/hi_sim_pkg.sv
// Shared mode encodings and the mode-to-divider-index mapping for hi_sim_multimode.
// HI_SIM_MANCHESTER_EN adds the Manchester 424K mode (k=5).
package hi_sim_pkg;

    localparam logic [2:0] MOD_NONE       = 3'b000;
    localparam logic [2:0] MOD_BPSK       = 3'b001;
    localparam logic [2:0] MOD_212K       = 3'b010;
    localparam logic [2:0] MOD_MANCH_424K = 3'b011;
    localparam logic [2:0] MOD_424K       = 3'b100;
    localparam logic [2:0] MOD_424K_8BIT  = 3'b101;
    localparam logic [2:0] MOD_848K       = 3'b110;

    // Divider bit that forms the SSP bit clock for a given mode.
    function automatic logic [2:0] mode_k(input logic [2:0] mode);
        case (mode)
            MOD_212K:       return 3'd5;
            MOD_424K_8BIT:  return 3'd7;
`ifdef HI_SIM_MANCHESTER_EN
            MOD_MANCH_424K: return 3'd5;
`endif
            default:        return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/hi_hyst_cmp.sv
// Hysteresis comparator on the peak-detector ADC sample: set at or above
// hyst_hi, clear at or below hyst_lo, hold in between.
module hi_hyst_cmp #(
    parameter int unsigned            ADC_W   = 8,
    parameter logic [ADC_W-1:0]       HYST_HI = ADC_W'(8'hE0),
    parameter logic [ADC_W-1:0]       HYST_LO = ADC_W'(8'h1F)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_d,
    output logic             after_hyst
);

    always_ff @(posedge clk) begin
        if (reset) begin
            after_hyst <= 1'b0;
        end else if (adc_d >= HYST_HI) begin
            after_hyst <= 1'b1;
        end else if (adc_d <= HYST_LO) begin
            after_hyst <= 1'b0;
        end
    end

endmodule

// File: rtl/hi_sim_multimode.sv
// HF ISO 14443 tag simulator: load modulation on pwr_oe1/pwr_oe4, hysteresis
// demod bitstream to SSP. HI_SIM_MANCHESTER_EN enables mode 3'b011.
module hi_sim_multimode
    import hi_sim_pkg::*;
#(
    parameter int unsigned      ADC_W      = 8,
    parameter logic [ADC_W-1:0] HYST_HI    = ADC_W'(8'hE0),
    parameter logic [ADC_W-1:0] HYST_LO    = ADC_W'(8'h1F),
    parameter int unsigned      DIV_W      = 8,
    parameter int unsigned      FRAME_BITS = 8
) (
    input  logic             ck_1356meg,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_d,
    input  logic [2:0]       mod_type,
    input  logic             ssp_dout,
    output logic             adc_clk,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din,
    output logic             pwr_oe1,
    output logic             pwr_oe4,
    output logic             pwr_hi,
    output logic             pwr_lo,
    output logic             pwr_oe2,
    output logic             pwr_oe3,
    output logic             dbg
);

    localparam int unsigned CW = $clog2(FRAME_BITS);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] low_mask;
    logic [2:0]       mode_q;
    logic [2:0]       k;
    logic [CW-1:0]    to_arm;
    logic [CW-1:0]    from_arm;
    logic             after_hyst;
    logic             tx_bit;
    logic             low_ones;
    logic             rise;
    logic             fall;
    logic             mode_chg;
    logic             m;
    logic             mod_q;

    hi_hyst_cmp #(
        .ADC_W   (ADC_W),
        .HYST_HI (HYST_HI),
        .HYST_LO (HYST_LO)
    ) u_hyst (
        .clk        (ck_1356meg),
        .reset      (reset),
        .adc_d      (adc_d),
        .after_hyst (after_hyst)
    );

    // Strobes fire on the last cycle of each ssp_clk half-period.
    always_comb begin
        k        = mode_k(mod_type);
        low_mask = ~({DIV_W{1'b1}} << k);
        low_ones = ((div & low_mask) == low_mask);
        rise     = low_ones & ~div[k];
        fall     = low_ones &  div[k];
        mode_chg = (mod_type != mode_q);
    end

    always_comb begin
        m = 1'b0;
        case (mod_type)
            MOD_BPSK:                m = tx_bit ^ div[3];
            MOD_212K:                m = tx_bit & div[5];
            MOD_424K, MOD_424K_8BIT: m = tx_bit & div[4];
            MOD_848K:                m = tx_bit & div[3];
`ifdef HI_SIM_MANCHESTER_EN
            MOD_MANCH_424K:          m = div[4] & (tx_bit ? ~div[5] : div[5]);
`endif
            default:                 m = 1'b0;
        endcase
    end

    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            div      <= '0;
            mode_q   <= mod_type;
            ssp_clk  <= 1'b0;
            ssp_din  <= 1'b0;
            to_arm   <= '0;
            from_arm <= '0;
            tx_bit   <= 1'b0;
            mod_q    <= 1'b0;
        end else begin
            div     <= div + DIV_W'(1);
            mode_q  <= mod_type;
            ssp_clk <= div[k];
            if (rise) begin
                ssp_din <= after_hyst;
            end
            // A mode change restarts framing and silences the load; it beats any strobe.
            if (mode_chg) begin
                to_arm   <= '0;
                from_arm <= '0;
                tx_bit   <= 1'b0;
                mod_q    <= 1'b0;
            end else begin
                mod_q <= m;
                if (rise) begin
                    to_arm <= to_arm + CW'(1);
                end
                if (fall) begin
                    from_arm <= from_arm + CW'(1);
                    tx_bit   <= ssp_dout;
                end
            end
        end
    end

    assign ssp_frame = (mod_type == MOD_NONE) ? (to_arm == '0) : (from_arm == '0);
    assign pwr_oe1   = mod_q;
    assign pwr_oe4   = mod_q;
    assign adc_clk   = ck_1356meg;
    assign dbg       = ssp_din;
    assign pwr_hi    = 1'b0;
    assign pwr_lo    = 1'b0;
    assign pwr_oe2   = 1'b0;
    assign pwr_oe3   = 1'b0;

endmodule
